// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg: definitions shared by the fetch-stage files.
//   XLEN              architectural register / address width
//   RESET_PC_DEFAULT  default first fetch address after reset
//   INSTR_BYTES       size of one instruction word in bytes
//   fetch_entry_t     one buffered fetch result {instr, pc}
//   align_pc()        clears the sub-word bits of a fetch address
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Misaligned redirect targets are silently forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo: synchronous instruction buffer for the fetch stage.
//   clk_i    clock
//   rst_i    synchronous active-high reset, empties the buffer
//   flush_i  synchronous clear, takes priority over push/pop
//   push_i   write data_i at the tail
//   data_i   entry to write
//   pop_i    drop the head entry
//   head_o   head entry, all-zero while empty
//   empty_o  no entries stored
//   count_o  number of entries stored
// Push and pop in the same cycle are both honoured at any occupancy,
// including full, so the fetch stage can stream one entry per cycle.
// ---------------------------------------------------------------------------
module if_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic do_push;
    logic do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction fetch stage.
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   br_taken_i     redirect from execute (flushes buffered and in-flight work)
//   new_pc_i       redirect target, low two bits ignored
//   imem_req_o     fetch request
//   imem_addr_o    word-aligned fetch address
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  in-order response valid
//   imem_rdata_i   response instruction word
//   instr_valid_o  buffered instruction available
//   instr_ready_i  decode accepts
//   instr_o        instruction at buffer head
//   pc_o           PC of instr_o
//
// Handshakes: a memory request transfers in a cycle where imem_req_o and
// imem_gnt_i are both high; imem_addr_o holds while req is waiting for gnt
// (req may also drop without gnt). A decode transfer happens in a cycle where
// instr_valid_o and instr_ready_i are both high. Neither valid nor req
// depends combinationally on the matching ready/gnt.
// ---------------------------------------------------------------------------
module if_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] new_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    // Counters hold up to 2*FIFO_DEPTH so credit sums never overflow.
    localparam int CNT_W  = $clog2(2 * FIFO_DEPTH + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_in;

    logic [CNT_W-1:0]  live_inflight;
    logic [CNT_W-1:0]  occupancy;
    logic              grant;
    logic              rsp_drop;
    logic [CNT_W-1:0]  grant_cnt;
    logic [CNT_W-1:0]  rsp_cnt;

    // Credit: buffered entries plus responses that will be kept must leave
    // room for one more, so every kept response always finds a free slot.
    assign live_inflight = outstanding_q - discard_q;
    assign occupancy     = CNT_W'(fifo_count) + live_inflight;

    assign imem_req_o  = !rst_i && !br_taken_i
                         && (occupancy < CNT_W'(FIFO_DEPTH))
                         && (outstanding_q < CNT_W'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc_q;

    assign grant     = imem_req_o && imem_gnt_i;
    assign rsp_drop  = (discard_q != '0);
    assign grant_cnt = CNT_W'(grant);
    assign rsp_cnt   = CNT_W'(imem_rvalid_i);

    // Responses arriving during a redirect or while stale requests remain
    // unanswered never enter the buffer.
    assign fifo_push = !rst_i && imem_rvalid_i && !br_taken_i && !rsp_drop;
    assign fifo_in   = '{instr: imem_rdata_i, pc: resp_pc_q};

    assign instr_valid_o = !rst_i && !fifo_empty && !br_taken_i;
    assign fifo_pop      = instr_valid_o && instr_ready_i;
    assign instr_o       = rst_i ? '0 : fifo_head.instr;
    assign pc_o          = rst_i ? '0 : fifo_head.pc;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (br_taken_i) begin
            // Everything still unanswered after this cycle becomes stale.
            // Adding to discard_q is unnecessary: it is a subset of
            // outstanding_q, which already counts those requests.
            fetch_pc_d    = align_pc(new_pc_i);
            resp_pc_d     = align_pc(new_pc_i);
            outstanding_d = outstanding_q - rsp_cnt;
            discard_d     = outstanding_q - rsp_cnt;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            outstanding_d = outstanding_q + grant_cnt - rsp_cnt;
            if (imem_rvalid_i && rsp_drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (fifo_push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (br_taken_i),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the didactic RISC-V core.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions together with their PCs, and hands them to decode with valid/ready.
- Consumes the execute stage's br_taken/new_pc redirect: it flushes buffered work and drops in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; legal range is 2 to 16.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- br_taken_i  in  1  redirect from execute
- new_pc_i  in  32  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word-aligned fetch address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses arrive in order, at most 1 per cycle, at least 1 cycle after gnt
- imem_rdata_i  in  32  instruction word
- instr_valid_o  out  1  buffered instruction available
- instr_ready_i  in  1  decode accepts
- instr_o  out  32  instruction at buffer head
- pc_o  out  32  PC of instr_o

Interface decision: one clock, clk_i; rst_i synchronous, active-high.

Behaviour:
- Reset (rst_i sampled high on a clock edge):
  - fetch_pc_q and resp_pc_q = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0.
  - In-flight responses during reset are ignored.
  - Reset mid-operation drops everything. The memory is reset with the core, so no late responses arrive.
- Counters:
  - outstanding counts granted requests not yet answered.
  - discard counts the subset of those to be dropped. Invariant: discard <= outstanding.
  - Counter width is clog2(2*FIFO_DEPTH+1).
- Request issue:
  - imem_req_o = !br_taken_i && (fifo_count + outstanding - discard) < FIFO_DEPTH && outstanding < FIFO_DEPTH.
  - Uses registered counts only.
  - imem_addr_o = fetch_pc_q.
  - On req && gnt: fetch_pc_q += 4 (wraps modulo 2^32) and outstanding++.
  - req may drop without gnt; the address stays stable until granted or redirected.
- Response:
  - On rvalid: outstanding--.
  - If discard > 0: discard--, data dropped.
  - Otherwise push {imem_rdata_i, resp_pc_q} and resp_pc_q += 4.
  - The credit rule guarantees the FIFO never overflows. The bench asserts push while full never occurs.
- Output:
  - instr_valid_o = !fifo_empty && !br_taken_i.
  - instr_o/pc_o come from the head entry and are registered. Fetch-to-decode latency is 1 cycle after rvalid.
  - Pop on instr_valid_o && instr_ready_i.
  - Simultaneous push and pop is allowed at any occupancy, including full.
- Redirect (br_taken_i = 1 in cycle t):
  - No request is issued and no pop occurs in cycle t.
  - FIFO cleared; any rvalid in cycle t is dropped.
  - At the t+1 edge: discard = outstanding - rvalid (the count still unanswered); fetch_pc_q = resp_pc_q = {new_pc_i[31:2], 2'b00}.
  - Misaligned low bits are silently cleared.
  - First request to the new PC is in cycle t+1.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Best-case latency with 1-cycle memory:
  - req+gnt at t, rvalid at t+1, instr_valid_o at t+2.
  - Sustained 1 instr/cycle for FIFO_DEPTH >= 3.

Decomposition:
- Shared package core_pkg holds:
  - XLEN = 32
  - RESET_PC_DEFAULT
  - INSTR_BYTES = 4
  - the fetch-entry struct {instr[31:0], pc[31:0]}
- One sub-module, if_fifo: synchronous FIFO with a flush input, parameterised depth, count output.
- The PC/credit/discard logic stays in if_stage.

Test Plan:
- Reset release, memory always grants, rvalid 1 cycle later, decode always ready, RESET_PC = 0x100 -> requests to 0x100, 0x104, 0x108…; instr_valid_o first high 2 cycles after the first req; one instruction per cycle with pc_o matching.
- Decode ready held low for 10 cycles, FIFO_DEPTH = 4 -> at most 4 buffered plus 0 extra outstanding; imem_req_o drops; no overflow; release returns PCs in order with no gap or duplicate.
- Redirect with 2 requests outstanding to 0x200/0x204, new_pc_i = 0x80 -> both responses dropped; next pc_o = 0x80 with instr_o equal to the memory word at 0x80; nothing from 0x200 ever reaches decode.
- Redirect in the same cycle as rvalid and a decode handshake attempt -> instr_valid_o = 0 that cycle; the rvalid data is dropped; discard = outstanding - 1.
- new_pc_i = 0x000000C6 -> fetch resumes at 0xC4.
- fetch_pc near 0xFFFFFFF8 -> 0xFFFFFFFC then 0x00000000.
- rst_i asserted with 3 outstanding and a full FIFO -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
